psum_align_fifo: RTL and testbench
==================================

# psum_align_fifo

Output-side collection buffer sitting directly downstream of the array of MAC columns. Each column presents its partial sum together with a write strobe, and the strobes arrive staggered one cycle per column because the instruction ripples across the array. This block absorbs that skew with one queue per column. It presents a complete, row-aligned vector of `col` psums to the readout logic once every column holds at least one entry.

## Interface
Parameters:
- `col`, 8: number of MAC columns / queues.
- `bw_psum`, 22: width of one partial sum, signed.
- `depth`, 16: entries per column queue; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-low; state clears on a rising `clk` edge while `reset` = 0.
- `wr`, in, `col`: per-column write strobe; bit i is column i's fifo write.
- `in`, in, `col*bw_psum`: column psums; column i occupies bits `[(i+1)*bw_psum-1 : i*bw_psum]`.
- `rd`, in, 1: pop one aligned row.
- `out`, out, `col*bw_psum`: registered popped row, same packing as `in`.
- `o_valid`, out, 1: every column queue is non-empty; a row is available.
- `o_full`, out, 1: at least one column queue is full.
- `o_ready`, out, 1: equals `~o_full`.
- `o_overflow`, out, 1: sticky; a write was dropped on a full queue.

## Operation
- Each column queue has:
  - its own write pointer;
  - a shared-width read pointer, `log2(depth)` bits, wrapping modulo `depth`;
  - an occupancy count of `log2(depth)+1` bits.
- Write acceptance for column i: `wr[i]` is accepted if `count_i < depth`, or if a pop is accepted in the same cycle. An accepted write stores `in` slice i at the write pointer and advances that pointer.
- Write drop: `wr[i]` on a full queue with no same-cycle pop is dropped. It sets `o_overflow`, which stays at 1 until reset. The pointer and count are unchanged.
- Read acceptance: `rd` is accepted only when `o_valid` = 1. All `col` queues then pop simultaneously, and the heads are latched into `out`.
- Read ignored: `rd` with `o_valid` = 0 is ignored. No pointer moves and `out` holds.
- Simultaneous push and pop on the same queue: both take effect and the count is unchanged. On an empty queue, pop cannot occur because `o_valid` = 0, so only the push happens.
- Data is passed unmodified. There is no sign extension or arithmetic.
- `out` holds its last popped value until the next accepted `rd`.
- Reset values: all counts and pointers 0, `out` = 0, `o_valid` = 0, `o_full` = 0, `o_ready` = 1, `o_overflow` = 0. Queue storage is not cleared.
- Reset mid-operation: queued rows are discarded. A `wr` or `rd` in the reset cycle is ignored.

## Timing
- Write-to-valid latency: a row whose last write (column `col-1`) lands at edge N raises `o_valid` after edge N, i.e. it is visible in cycle N+1.
- Read latency: `rd` accepted at edge N updates `out` at edge N. New data is visible in cycle N+1.
- Flag updates: `o_valid`, `o_full` and `o_ready` are derived from registered counts and update at the same edge as the count change.
- Back-to-back: `rd` may be held high continuously, popping one row per cycle while `o_valid` = 1.
- Skew: column i's write normally lags column i-1's write by one cycle. The block does not depend on that skew; any per-column arrival order is legal.

## Structure
- Shared package holds:
  - default constants for `col`, `bw_psum`, `depth`;
  - the derived pointer width `log2(depth)` and count width `log2(depth)+1`.
- One sub-module, `psum_col_queue`: a single-column synchronous FIFO with push, pop, data in/out, count, full and empty.
  - Instantiated `col` times through a generate loop.
  - Top level does the AND of non-empty flags, the OR of full flags, the overflow register and the `out` register.

## Test plan
- Reset behaviour: hold `reset`=0 for 2 cycles while driving `wr`=all ones and `rd`=1 → after release, all counts are 0, `o_valid`=0, `o_ready`=1, `o_overflow`=0, `out`=0.
- Single skewed row: drive column i with `wr[i]`=1 and value i+1 in cycle i, for i = 0..7.
  - `o_valid` stays 0 until the cycle after column 7 is written, then rises to 1.
  - Pulse `rd` → next cycle `out` slices = 1..8 and `o_valid`=0.
- Fill and overflow: write 16 rows of value k (k = 0..15) to all columns → `o_full`=1, `o_ready`=0.
  - A 17th write drops and sets `o_overflow`=1.
  - 16 pops return 0..15 in order, and `o_overflow` remains 1.
- Full with simultaneous push/pop: with all queues full, drive `wr`=all ones and `rd`=1 in the same cycle → write accepted, `o_overflow` stays 0, count stays 16, and the popped row is the oldest.
- Read while empty / pointer wrap: `rd`=1 on an empty block → `out` unchanged.
  - Then stream 40 rows with `rd` held high (the pointers wrap twice) → rows come out in order with no loss or duplication.
- Reset mid-stream: with 5 rows queued, assert `reset` for 1 cycle → `o_valid`=0.
  - Next written row is the next one read, not any stale row.

Source files
------------

// File: rtl/psum_align_fifo_pkg.sv
// psum_align_fifo_pkg: default sizing and derived widths for the psum alignment fifo
package psum_align_fifo_pkg;
  localparam int COL = 8;
  localparam int BW_PSUM = 22;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
endpackage

// File: rtl/psum_col_queue.sv
// psum_col_queue: single-column synchronous fifo holding one MAC column's psums
module psum_col_queue
  import psum_align_fifo_pkg::*;
#(
  parameter int bw_psum = BW_PSUM,
  parameter int depth = DEPTH,
  localparam int pw = $clog2(depth),
  localparam int cw = pw + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [bw_psum-1:0] din,
  output logic [bw_psum-1:0] dout,
  output logic [cw-1:0]      count,
  output logic               full,
  output logic               empty
);
  logic [bw_psum-1:0] mem [depth];
  logic [pw-1:0] wptr, rptr;
  logic push_ok, pop_ok;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign full = count == cw'(depth);
  assign empty = count == '0;
  assign dout = mem[rptr];
  always_ff @(posedge clk)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + pw'(push_ok);
      rptr <= rptr + pw'(pop_ok);
      count <= count + cw'(push_ok) - cw'(pop_ok);
    end
  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk)
    if (reset && push_ok) mem[wptr] <= din;
endmodule

// File: rtl/psum_align_fifo.sv
// psum_align_fifo: per-column queues that absorb MAC column skew and emit aligned psum rows
module psum_align_fifo
  import psum_align_fifo_pkg::*;
#(
  parameter int col = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int depth = DEPTH,
  localparam int cw = $clog2(depth) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow
);
  logic [col-1:0] full, empty, push;
  logic [cw-1:0] cnt [col];
  logic [col*bw_psum-1:0] head;
  logic pop;
  assign pop = rd & o_valid;
  assign o_valid = ~|empty;
  assign o_full = |full;
  assign o_ready = ~o_full;
  for (genvar i = 0; i < col; i++) begin : g_q
    // a same-cycle pop frees a slot, so a full queue may still take a write
    assign push[i] = wr[i] & ((cnt[i] < cw'(depth)) | pop);
    psum_col_queue #(.bw_psum(bw_psum), .depth(depth)) u_q (
      .clk(clk),
      .reset(reset),
      .push(push[i]),
      .pop(pop),
      .din(in[i*bw_psum +: bw_psum]),
      .dout(head[i*bw_psum +: bw_psum]),
      .count(cnt[i]),
      .full(full[i]),
      .empty(empty[i])
    );
  end
  always_ff @(posedge clk)
    if (!reset) begin
      out <= '0;
      o_overflow <= 1'b0;
    end else begin
      out <= pop ? head : out;
      o_overflow <= o_overflow | |(wr & ~push);
    end
endmodule

// File: tb/tb_psum_align_fifo.sv
// tb_psum_align_fifo: table vectors, directed corner sequences and random traffic against a queue model
module tb_psum_align_fifo;
  logic clk = 0, reset = 0, rd = 0;
  logic [7:0] wr = '0;
  logic [175:0] in = '0, out;
  logic o_valid, o_full, o_ready, o_overflow;
  int checks = 0, errors = 0;
  logic [21:0] mq [8][$];
  logic [175:0] om = '0;
  logic ovf = 0;

  psum_align_fifo dut (
    .clk(clk), .reset(reset), .wr(wr), .in(in), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   w;
    logic [21:0]  val;
    logic         r;
    logic         ev;
    logic [175:0] eout;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string n, input logic [175:0] a, input logic [175:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  task automatic cyc(input logic [7:0] w, input logic [175:0] d, input logic r, input logic rs);
    bit v, f;
    v = 1;
    for (int i = 0; i < 8; i++) if (mq[i].size() == 0) v = 0;
    wr = w; in = d; rd = r; reset = rs;
    if (!rs) begin
      for (int i = 0; i < 8; i++) mq[i].delete();
      om = '0;
      ovf = 0;
    end else begin
      if (r && v) for (int i = 0; i < 8; i++) om[i*22 +: 22] = mq[i].pop_front();
      for (int i = 0; i < 8; i++)
        if (w[i]) begin
          if (mq[i].size() < 16) mq[i].push_back(d[i*22 +: 22]);
          else ovf = 1;
        end
    end
    @(posedge clk);
    #1;
    v = 1; f = 0;
    for (int i = 0; i < 8; i++) begin
      if (mq[i].size() == 0) v = 0;
      if (mq[i].size() == 16) f = 1;
    end
    chk("out", out, om);
    chk("o_valid", 176'(o_valid), 176'(v));
    chk("o_full", 176'(o_full), 176'(f));
    chk("o_ready", 176'(o_ready), 176'(!f));
    chk("o_overflow", 176'(o_overflow), 176'(ovf));
  endtask

  task automatic fill(input int n, input int base);
    for (int k = 0; k < n; k++) cyc(8'hFF, {8{22'(base + k)}}, 1'b0, 1'b1);
  endtask

  task automatic rst1();
    cyc(8'h00, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [175:0] r18, d;
    r18 = '0;
    for (int i = 0; i < 8; i++) r18[i*22 +: 22] = 22'(i + 1);
    for (int i = 0; i < 8; i++) tbl[i] = '{8'(1 << i), 22'(i + 1), 1'b0, (i == 7), 176'd0};
    tbl[8] = '{8'h00, 22'd0, 1'b1, 1'b0, r18};
    tbl[9] = '{8'h00, 22'd0, 1'b1, 1'b0, r18};

    cyc(8'hFF, {8{22'h3FFFFF}}, 1'b1, 1'b0);
    cyc(8'hFF, {8{22'h3FFFFF}}, 1'b1, 1'b0);
    chk("rst_valid", 176'(o_valid), 176'd0);
    chk("rst_ready", 176'(o_ready), 176'd1);
    chk("rst_ovf", 176'(o_overflow), 176'd0);
    chk("rst_out", out, 176'd0);

    for (int t = 0; t < 10; t++) begin
      cyc(tbl[t].w, {8{tbl[t].val}}, tbl[t].r, 1'b1);
      chk($sformatf("tbl%0d_valid", t), 176'(o_valid), 176'(tbl[t].ev));
      chk($sformatf("tbl%0d_out", t), out, tbl[t].eout);
    end

    rst1();
    fill(16, 0);
    chk("fill_full", 176'(o_full), 176'd1);
    chk("fill_ready", 176'(o_ready), 176'd0);
    cyc(8'hFF, {8{22'd99}}, 1'b0, 1'b1);
    chk("drop_ovf", 176'(o_overflow), 176'd1);
    for (int k = 0; k < 16; k++) begin
      cyc(8'h00, '0, 1'b1, 1'b1);
      chk($sformatf("pop%0d", k), out, {8{22'(k)}});
    end
    chk("drain_ovf", 176'(o_overflow), 176'd1);
    chk("drain_valid", 176'(o_valid), 176'd0);

    rst1();
    fill(16, 200);
    cyc(8'hFF, {8{22'd77}}, 1'b1, 1'b1);
    chk("pp_ovf", 176'(o_overflow), 176'd0);
    chk("pp_full", 176'(o_full), 176'd1);
    chk("pp_out", out, {8{22'd200}});

    rst1();
    cyc(8'h00, '0, 1'b1, 1'b1);
    chk("empty_rd_out", out, 176'd0);
    for (int k = 0; k < 40; k++) cyc(8'hFF, {8{22'(1000 + k)}}, 1'b1, 1'b1);
    chk("stream_last", out, {8{22'd1038}});

    rst1();
    fill(5, 300);
    cyc(8'hFF, {8{22'd5}}, 1'b1, 1'b0);
    chk("midrst_valid", 176'(o_valid), 176'd0);
    cyc(8'hFF, {8{22'd500}}, 1'b0, 1'b1);
    cyc(8'h00, '0, 1'b1, 1'b1);
    chk("midrst_fresh", out, {8{22'd500}});

    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 8; i++) d[i*22 +: 22] = 22'($urandom);
      cyc(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF, d,
          $urandom_range(0, 2) != 0, $urandom_range(0, 80) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
